// File: rtl/rv32i_trap_sequencer_if.sv
// Handshake between the interrupt controller and the trap sequencer.
// The controller drives state/offset; the sequencer answers with advance/clear.
interface rv32i_trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic [1:0]      interrupt_state_i;
  logic [XLEN-1:0] interrupt_vector_offset_i;
  logic            interrupt_advance_o;
  logic            clear_interrupt_o;

  modport master (
    output interrupt_state_i,
    output interrupt_vector_offset_i,
    input  interrupt_advance_o,
    input  clear_interrupt_o
  );

  modport slave (
    input  interrupt_state_i,
    input  interrupt_vector_offset_i,
    output interrupt_advance_o,
    output clear_interrupt_o
  );
endinterface

// File: rtl/rv32i_trap_sequencer.sv
// Takes traps at instruction boundaries, redirects fetch to mtvec+offset,
// and restores PC and global enable on mret.
module rv32i_trap_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  rv32i_trap_sequencer_if.slave irq,
  input  logic                  instr_boundary_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic                  mret_i,
  input  logic                  mtvec_write_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic                  mie_write_i,
  input  logic                  mie_i,
  output logic                  mie_o,
  output logic [XLEN-1:0]       mepc_o,
  output logic                  pc_load_o,
  output logic [XLEN-1:0]       pc_load_value_o,
  output logic                  stall_o,
  output logic                  in_handler_o
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_TAKE,
    S_HANDLER,
    S_RELEASE
  } state_e;

  localparam logic [1:0] CS_IDLE    = 2'b00;
  localparam logic [1:0] CS_PENDING = 2'b01;
  localparam logic [1:0] CS_HANDLE  = 2'b10;

  state_e          state_q, state_d;
  logic [XLEN-1:2] mtvec_q;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;

  logic [XLEN-1:0] vec_target;
  logic            unused_ok;

  assign unused_ok  = &{1'b0, mtvec_i[1:0]};
  assign vec_target = {mtvec_q, 2'b00} + irq.interrupt_vector_offset_i;

  always_comb begin
    state_d             = state_q;
    mepc_d              = mepc_q;
    mie_d               = mie_write_i ? mie_i : mie_q;
    mpie_d              = mpie_q;
    irq.interrupt_advance_o = 1'b0;
    irq.clear_interrupt_o   = 1'b0;
    pc_load_o           = 1'b0;
    pc_load_value_o     = '0;
    stall_o             = 1'b0;
    in_handler_o        = 1'b0;
    unique case (state_q)
      S_FLUSH: begin
        stall_o = 1'b1;
        // controller keeps its state across our reset; walk it back to idle
        unique case (irq.interrupt_state_i)
          CS_PENDING: irq.interrupt_advance_o = 1'b1;
          CS_HANDLE:  irq.clear_interrupt_o   = 1'b1;
          CS_IDLE:    state_d = S_IDLE;
          default:    ;
        endcase
      end
      S_IDLE: begin
        if (irq.interrupt_state_i == CS_PENDING && mie_q && instr_boundary_i) begin
          mepc_d  = pc_i;
          state_d = S_TAKE;
        end
      end
      S_TAKE: begin
        stall_o                 = 1'b1;
        pc_load_o               = 1'b1;
        pc_load_value_o         = vec_target;
        irq.interrupt_advance_o = 1'b1;
        mpie_d                  = mie_q;
        mie_d                   = 1'b0;
        state_d                 = S_HANDLER;
      end
      S_HANDLER: begin
        in_handler_o = 1'b1;
        if (mret_i) begin
          pc_load_o             = 1'b1;
          pc_load_value_o       = mepc_q;
          irq.clear_interrupt_o = 1'b1;
          mie_d                 = mpie_q;
          mpie_d                = 1'b1;
          state_d               = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FLUSH;
      mtvec_q <= RESET_MTVEC[XLEN-1:2];
      mepc_q  <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mepc_q  <= mepc_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      if (mtvec_write_i)
        mtvec_q <= mtvec_i[XLEN-1:2];
    end
  end

  assign mie_o  = mie_q;
  assign mepc_o = mepc_q;

endmodule

// File: tb/tb_rv32i_trap_sequencer.sv
// Scoreboarded bench: redirect targets are queued when a trap or mret
// is set up and popped whenever the sequencer pulses pc_load_o.
module tb_rv32i_trap_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            instr_boundary_i;
  logic [XLEN-1:0] pc_i;
  logic            mret_i;
  logic            mtvec_write_i;
  logic [XLEN-1:0] mtvec_i;
  logic            mie_write_i;
  logic            mie_i;
  logic            mie_o;
  logic [XLEN-1:0] mepc_o;
  logic            pc_load_o;
  logic [XLEN-1:0] pc_load_value_o;
  logic            stall_o;
  logic            in_handler_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] sb_q[$];

  rv32i_trap_sequencer_if #(.XLEN(XLEN)) irq ();

  rv32i_trap_sequencer #(.XLEN(XLEN), .RESET_MTVEC(32'h0)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .irq              (irq.slave),
    .instr_boundary_i (instr_boundary_i),
    .pc_i             (pc_i),
    .mret_i           (mret_i),
    .mtvec_write_i    (mtvec_write_i),
    .mtvec_i          (mtvec_i),
    .mie_write_i      (mie_write_i),
    .mie_i            (mie_i),
    .mie_o            (mie_o),
    .mepc_o           (mepc_o),
    .pc_load_o        (pc_load_o),
    .pc_load_value_o  (pc_load_value_o),
    .stall_o          (stall_o),
    .in_handler_o     (in_handler_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got,
                     input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (pc_load_o === 1'b1) begin
      if (sb_q.size() == 0)
        chk("pc_load_unexpected", {31'b0, pc_load_o}, 32'h0);
      else
        chk("pc_load_value", pc_load_value_o, sb_q.pop_front());
    end
  end

  initial begin
    reset_i = 1'b1;
    instr_boundary_i = 1'b0;
    pc_i = '0;
    mret_i = 1'b0;
    mtvec_write_i = 1'b0;
    mtvec_i = '0;
    mie_write_i = 1'b0;
    mie_i = 1'b0;
    irq.interrupt_state_i = 2'b00;
    irq.interrupt_vector_offset_i = '0;

    tick(); tick();
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'h1);
    chk("rst_mie", {31'b0, mie_o}, 32'h0);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_adv", {31'b0, irq.interrupt_advance_o}, 32'h0);
    reset_i = 1'b0;
    // FLUSH -> IDLE on controller idle; write CSRs
    mtvec_write_i = 1'b1; mtvec_i = 32'h100;
    mie_write_i = 1'b1; mie_i = 1'b1;
    tick();
    mtvec_write_i = 1'b0; mie_write_i = 1'b0;
    irq.interrupt_state_i = 2'b01;
    #1;
    chk("idle_stall", {31'b0, stall_o}, 32'h0);
    tick();
    irq.interrupt_vector_offset_i = 32'h0C;
    instr_boundary_i = 1'b1;
    pc_i = 32'h2040;
    sb_q.push_back(32'h10C);
    #1;
    chk("t1_no_adv_idle", {31'b0, irq.interrupt_advance_o}, 32'h0);
    tick();
    instr_boundary_i = 1'b0;
    #1;
    chk("t1_adv", {31'b0, irq.interrupt_advance_o}, 32'h1);
    chk("t1_stall", {31'b0, stall_o}, 32'h1);
    chk("t1_mepc", mepc_o, 32'h2040);
    tick();
    irq.interrupt_state_i = 2'b10;
    #1;
    chk("t1_mie_off", {31'b0, mie_o}, 32'h0);
    chk("t1_in_handler", {31'b0, in_handler_o}, 32'h1);
    chk("t1_adv_once", {31'b0, irq.interrupt_advance_o}, 32'h0);
    tick();
    // mret: same-cycle redirect to mepc
    mret_i = 1'b1;
    sb_q.push_back(32'h2040);
    #1;
    chk("t2_clear", {31'b0, irq.clear_interrupt_o}, 32'h1);
    tick();
    mret_i = 1'b0;
    irq.interrupt_state_i = 2'b00;
    #1;
    chk("t2_mie_back", {31'b0, mie_o}, 32'h1);
    chk("t2_release_clr", {31'b0, irq.clear_interrupt_o}, 32'h0);
    chk("t2_release_hdl", {31'b0, in_handler_o}, 32'h0);
    tick();
    // mret in IDLE is ignored
    mret_i = 1'b1;
    #1;
    chk("t6_idle_mret_clr", {31'b0, irq.clear_interrupt_o}, 32'h0);
    tick();
    mret_i = 1'b0;
    // gated by mie=0
    mie_write_i = 1'b1; mie_i = 1'b0;
    tick();
    mie_write_i = 1'b0;
    irq.interrupt_state_i = 2'b01;
    irq.interrupt_vector_offset_i = 32'h20;
    instr_boundary_i = 1'b1;
    pc_i = 32'h3000;
    tick();
    #1;
    chk("t3_mie0_adv", {31'b0, irq.interrupt_advance_o}, 32'h0);
    chk("t3_mie0_stall", {31'b0, stall_o}, 32'h0);
    instr_boundary_i = 1'b0;
    mie_write_i = 1'b1; mie_i = 1'b1;
    tick();
    mie_write_i = 1'b0;
    #1;
    chk("t3_nobnd_adv", {31'b0, irq.interrupt_advance_o}, 32'h0);
    chk("t3_mie1", {31'b0, mie_o}, 32'h1);
    instr_boundary_i = 1'b1;
    sb_q.push_back(32'h120);
    tick();
    instr_boundary_i = 1'b0;
    // CSR write coincident with TAKE loses
    mie_write_i = 1'b1; mie_i = 1'b1;
    #1;
    chk("t3_adv", {31'b0, irq.interrupt_advance_o}, 32'h1);
    tick();
    mie_write_i = 1'b0;
    irq.interrupt_state_i = 2'b10;
    #1;
    chk("t6_take_mie", {31'b0, mie_o}, 32'h0);
    chk("t3_mepc", mepc_o, 32'h3000);
    mret_i = 1'b1;
    sb_q.push_back(32'h3000);
    tick();
    mret_i = 1'b0;
    irq.interrupt_state_i = 2'b00;
    tick();
    // mtvec wrap and low bits ignored
    mtvec_write_i = 1'b1; mtvec_i = 32'hFFFF_FFFC;
    tick();
    mtvec_write_i = 1'b0;
    irq.interrupt_state_i = 2'b01;
    irq.interrupt_vector_offset_i = 32'h14;
    instr_boundary_i = 1'b1;
    pc_i = 32'h44;
    sb_q.push_back(32'h10);
    tick();
    instr_boundary_i = 1'b0;
    mtvec_write_i = 1'b1; mtvec_i = 32'h103;
    tick();
    mtvec_write_i = 1'b0;
    irq.interrupt_state_i = 2'b10;
    mret_i = 1'b1;
    sb_q.push_back(32'h44);
    tick();
    mret_i = 1'b0;
    irq.interrupt_state_i = 2'b00;
    tick();
    irq.interrupt_state_i = 2'b01;
    irq.interrupt_vector_offset_i = 32'h8;
    instr_boundary_i = 1'b1;
    pc_i = 32'h88;
    sb_q.push_back(32'h108);
    tick();
    instr_boundary_i = 1'b0;
    tick();
    irq.interrupt_state_i = 2'b10;
    #1;
    chk("t5_in_handler", {31'b0, in_handler_o}, 32'h1);
    // reset mid-handler with controller still in 10
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    chk("t4_flush_clr", {31'b0, irq.clear_interrupt_o}, 32'h1);
    chk("t4_flush_stall", {31'b0, stall_o}, 32'h1);
    chk("t4_flush_mepc", mepc_o, 32'h0);
    tick();
    #1;
    chk("t4_flush_clr2", {31'b0, irq.clear_interrupt_o}, 32'h1);
    irq.interrupt_state_i = 2'b00;
    tick();
    #1;
    chk("t4_idle_stall", {31'b0, stall_o}, 32'h0);
    // reset with controller pending
    irq.interrupt_state_i = 2'b01;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    chk("t4_flush_adv", {31'b0, irq.interrupt_advance_o}, 32'h1);
    chk("t4_flush_noclr", {31'b0, irq.clear_interrupt_o}, 32'h0);
    tick();
    irq.interrupt_state_i = 2'b10;
    #1;
    chk("t4_flush_clr3", {31'b0, irq.clear_interrupt_o}, 32'h1);
    chk("t4_flush_noadv", {31'b0, irq.interrupt_advance_o}, 32'h0);
    tick();
    irq.interrupt_state_i = 2'b00;
    tick();
    #1;
    chk("t4_idle_end", {31'b0, stall_o}, 32'h0);
    tick(); tick();
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
